// File: rtl/pipeline_ctrl_if.sv
// Hazard-unit signal bundle between pipeline_ctrl and the 5-stage datapath.
// master = the controller side, slave = the datapath side.
interface pipeline_ctrl_if;
   logic [4:0]  ifid_rs;
   logic [4:0]  ifid_rt;
   logic        idex_memread;
   logic [4:0]  idex_rd;
   logic        exmem_branch;
   logic        exmem_zero;
   logic        exmem_memread;
   logic        exmem_memwrite;
   logic        dmem_ready;
   logic        dmem_req;
   logic        pc_en;
   logic        ifid_en;
   logic        idex_en;
   logic        exmem_en;
   logic        memwb_en;
   logic        ifid_flush;
   logic        idex_flush;
   logic        exmem_flush;
   logic        memwb_flush;
   logic        pc_branch;
   logic        halted;
   logic        mem_err;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   modport master (
      input  ifid_rs, ifid_rt, idex_memread, idex_rd, exmem_branch, exmem_zero,
             exmem_memread, exmem_memwrite, dmem_ready,
      output dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush,
             pc_branch, halted, mem_err, stall_cnt, flush_cnt
   );

   modport slave (
      output ifid_rs, ifid_rt, idex_memread, idex_rd, exmem_branch, exmem_zero,
             exmem_memread, exmem_memwrite, dmem_ready,
      input  dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush,
             pc_branch, halted, mem_err, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline with data-memory timeout watchdog.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   pipeline_ctrl_if.master pif
);
   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);
   localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [CW-1:0] wait_cnt_r;
   logic [CW-1:0] wait_cnt_nxt_s;
   logic          mem_err_r;
   logic          err_set_s;

   logic memop_s;
   logic branch_taken_s;
   logic load_use_s;
   logic mem_stall_s;
   logic take_branch_s;
   logic take_lu_s;
   logic req_s;

   logic dmem_req_s, pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s;
   logic ifid_flush_s, idex_flush_s, exmem_flush_s, memwb_flush_s;
   logic pc_branch_s, halted_s;

   assign memop_s        = pif.exmem_memread | pif.exmem_memwrite;
   assign branch_taken_s = pif.exmem_branch & pif.exmem_zero;
   assign load_use_s     = pif.idex_memread & (pif.idex_rd != 5'd0) &
                           ((pif.idex_rd == pif.ifid_rs) | (pif.idex_rd == pif.ifid_rt));

   // Next-state logic and hazard classification for the current cycle.
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      err_set_s      = 1'b0;
      mem_stall_s    = 1'b0;
      take_branch_s  = 1'b0;
      take_lu_s      = 1'b0;
      req_s          = 1'b0;
      case (state_r)
         RUN: begin
            req_s = memop_s;
            if (memop_s && !pif.dmem_ready) begin
               mem_stall_s    = 1'b1;
               state_nxt_s    = MEM_WAIT;
               wait_cnt_nxt_s = WAIT_ONE;
            end else begin
               // The branch flushes ID, so a coincident load-use is moot.
               take_branch_s = branch_taken_s;
               take_lu_s     = load_use_s & ~branch_taken_s;
            end
         end
         MEM_WAIT: begin
            req_s = 1'b1;
            if (pif.dmem_ready) begin
               state_nxt_s    = RUN;
               wait_cnt_nxt_s = {CW{1'b0}};
            end else begin
               mem_stall_s = 1'b1;
               if (wait_cnt_r == LAST_WAIT) begin
                  state_nxt_s = HALT;
                  err_set_s   = 1'b1;
               end else begin
                  wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
               end
            end
         end
         HALT: begin
            state_nxt_s = HALT;
         end
         default: begin
            // Corrupted state encoding: freeze rather than guess.
            state_nxt_s = HALT;
            err_set_s   = 1'b1;
         end
      endcase
   end

   // Stage enables and flushes, by priority reset > halt > mem stall > branch > load-use.
   always_comb begin
      dmem_req_s    = req_s;
      pc_en_s       = 1'b1;
      ifid_en_s     = 1'b1;
      idex_en_s     = 1'b1;
      exmem_en_s    = 1'b1;
      memwb_en_s    = 1'b1;
      ifid_flush_s  = 1'b0;
      idex_flush_s  = 1'b0;
      exmem_flush_s = 1'b0;
      memwb_flush_s = 1'b0;
      pc_branch_s   = 1'b0;
      halted_s      = 1'b0;
      if (rst) begin
         dmem_req_s    = 1'b0;
         {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b00000;
         {ifid_flush_s, idex_flush_s, exmem_flush_s, memwb_flush_s} = 4'b1111;
      end else if (state_r == HALT) begin
         dmem_req_s = 1'b0;
         {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b00000;
         halted_s   = 1'b1;
      end else if (mem_stall_s) begin
         {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s} = 4'b0000;
         memwb_flush_s = 1'b1;
      end else if (take_branch_s) begin
         pc_branch_s = 1'b1;
         {ifid_flush_s, idex_flush_s, exmem_flush_s} = 3'b111;
      end else if (take_lu_s) begin
         pc_en_s      = 1'b0;
         ifid_en_s    = 1'b0;
         idex_flush_s = 1'b1;
      end else begin
         pc_branch_s = 1'b0;
      end
   end

   // Sequencer state, wait counter and sticky timeout flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= RUN;
         wait_cnt_r <= {CW{1'b0}};
         mem_err_r  <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
         mem_err_r  <= mem_err_r | err_set_s;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_r;
   logic [31:0] flush_cnt_r;

   // Saturating stall and branch-flush counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= 32'd0;
         flush_cnt_r <= 32'd0;
      end else begin
         if (!pc_en_s && (state_r != HALT) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (pc_branch_s && (flush_cnt_r != 32'hFFFF_FFFF)) begin
            flush_cnt_r <= flush_cnt_r + 32'd1;
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign pif.stall_cnt = stall_cnt_r;
   assign pif.flush_cnt = flush_cnt_r;
`else
   assign pif.stall_cnt = 32'd0;
   assign pif.flush_cnt = 32'd0;
`endif

   assign pif.dmem_req    = dmem_req_s;
   assign pif.pc_en       = pc_en_s;
   assign pif.ifid_en     = ifid_en_s;
   assign pif.idex_en     = idex_en_s;
   assign pif.exmem_en    = exmem_en_s;
   assign pif.memwb_en    = memwb_en_s;
   assign pif.ifid_flush  = ifid_flush_s;
   assign pif.idex_flush  = idex_flush_s;
   assign pif.exmem_flush = exmem_flush_s;
   assign pif.memwb_flush = memwb_flush_s;
   assign pif.pc_branch   = pc_branch_s;
   assign pif.halted      = halted_s;
   assign pif.mem_err     = mem_err_r;
endmodule
